// File: rtl/ball_motion_sched.sv
// ball_motion_sched: per-frame ball motion sequencer. Detects new key presses in
// the four USB keycode slots, arbitrates them round-robin, queues direction
// commands, and applies them with hold time and edge-bounce priority.
// Optional feature macro: BALL_ACCEL_EN (repeated same-direction pops grow the step).
module ball_motion_sched #(
`ifdef BALL_ACCEL_EN
  parameter int unsigned MAX_STEP      = 4,
`endif
  parameter int unsigned STEP          = 1,
  parameter int unsigned HOLD_FRAMES   = 8,
  parameter int unsigned BOUNCE_FRAMES = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned X_MIN         = 0,
  parameter int unsigned X_MAX         = 639,
  parameter int unsigned Y_MIN         = 0,
  parameter int unsigned Y_MAX         = 479
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycodes,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [9:0]  BallS,
  output logic [9:0]  MotionX,
  output logic [9:0]  MotionY,
  output logic        Paused,
  output logic [2:0]  QCount,
  output logic        Dropped
);

  localparam int unsigned MW = 10;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned BW = $clog2(BOUNCE_FRAMES + 1);

  localparam logic [MW-1:0] STEP_V = MW'(STEP);

  localparam logic [7:0] KEY_W  = 8'h1A;
  localparam logic [7:0] KEY_S  = 8'h16;
  localparam logic [7:0] KEY_A  = 8'h04;
  localparam logic [7:0] KEY_D  = 8'h07;
  localparam logic [7:0] KEY_SP = 8'h2C;

  localparam logic [1:0] DIR_W = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_A = 2'd2;
  localparam logic [1:0] DIR_D = 2'd3;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_BOUNCE = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;

  function automatic logic key_ok(input logic [7:0] k);
    return (k == KEY_W) || (k == KEY_S) || (k == KEY_A) || (k == KEY_D) || (k == KEY_SP);
  endfunction

  function automatic logic is_new(input logic [7:0] k, input logic [31:0] prev);
    logic seen;
    seen = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (prev[8*j +: 8] == k) seen = 1'b1;
    end
    return key_ok(k) && !seen;
  endfunction

  // State
  logic [1:0]    state_q, state_d;
  logic [31:0]   prev_q;
  logic [3:0]    pend_q, pend_d;
  logic [1:0]    rr_q, rr_d;
  logic [MW-1:0] mx_q, mx_d, my_q, my_d;
  logic [MW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] bnc_q, bnc_d;
  logic [1:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_q;

  // Combinational
  logic [3:0]    req_c, grant_c;
  logic          gnt_vld_c;
  logic [1:0]    gnt_idx_c, cand_c;
  logic [7:0]    gnt_key_c;
  logic          space_c, push_req_c, push_ok_c, drop_c, pop_c;
  logic [1:0]    push_dir_c, pop_dir_c;
  logic [MW-1:0] cur_step_c, neg_step_c, pop_step_c, pop_neg_c;
  logic [MW-1:0] ex_c, ey_c;
  logic          edge_c;
  logic [HW-1:0] hold_dec_c;

  // Press detection: new valid key, or an ungranted press whose slot is unchanged
  always_comb begin
    req_c = '0;
    for (int i = 0; i < 4; i++) begin
      req_c[i] = is_new(keycodes[8*i +: 8], prev_q) ||
                 (pend_q[i] && (keycodes[8*i +: 8] == prev_q[8*i +: 8]));
    end
  end

  // Round-robin arbiter: one grant per frame, searching from the slot after the last grant
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = rr_q;
    cand_c    = rr_q;
    for (int k = 1; k <= 4; k++) begin
      cand_c = rr_q + 2'(k);
      if (!gnt_vld_c && req_c[cand_c]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = cand_c;
      end
    end
    grant_c    = gnt_vld_c ? (4'b0001 << gnt_idx_c) : 4'b0000;
    gnt_key_c  = keycodes[{gnt_idx_c, 3'b000} +: 8];
    space_c    = gnt_vld_c && (gnt_key_c == KEY_SP);
    push_req_c = gnt_vld_c && !space_c;
    case (gnt_key_c)
      KEY_W:   push_dir_c = DIR_W;
      KEY_S:   push_dir_c = DIR_S;
      KEY_A:   push_dir_c = DIR_A;
      default: push_dir_c = DIR_D;
    endcase
    pend_d = req_c & ~grant_c;
    rr_d   = gnt_vld_c ? gnt_idx_c : rr_q;
  end

  assign pop_dir_c = fifo_q[rd_q];

`ifdef BALL_ACCEL_EN
  localparam logic [MW-1:0] MAX_V = MW'(MAX_STEP);
  logic [MW-1:0] step_q;
  logic [1:0]    last_dir_q;
  logic          last_vld_q;

  assign cur_step_c = step_q;

  // Same-direction pops accelerate up to MAX_STEP; a new direction restarts at STEP
  always_comb begin
    pop_step_c = STEP_V;
    if (last_vld_q && (last_dir_q == pop_dir_c)) begin
      pop_step_c = (step_q >= MAX_V) ? MAX_V : MW'(step_q + MW'(1));
    end
  end

  // Step and last-direction tracking, updated on each pop
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      step_q     <= STEP_V;
      last_dir_q <= DIR_W;
      last_vld_q <= 1'b0;
    end else if (pop_c) begin
      step_q     <= pop_step_c;
      last_dir_q <= pop_dir_c;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign cur_step_c = STEP_V;
  assign pop_step_c = STEP_V;
`endif

  assign neg_step_c = MW'(~cur_step_c + MW'(1));
  assign pop_neg_c  = MW'(~pop_step_c + MW'(1));
  assign hold_dec_c = (hold_q == '0) ? '0 : HW'(hold_q - HW'(1));

  // Edge detection with fixed priority bottom > top > right > left; only one axis changes
  always_comb begin
    ex_c   = mx_q;
    ey_c   = my_q;
    edge_c = 1'b1;
    if (({1'b0, BallY} + {1'b0, BallS}) >= 11'(Y_MAX))      ey_c = neg_step_c;
    else if ({1'b0, BallY} <= (11'(Y_MIN) + {1'b0, BallS})) ey_c = cur_step_c;
    else if (({1'b0, BallX} + {1'b0, BallS}) >= 11'(X_MAX)) ex_c = neg_step_c;
    else if ({1'b0, BallX} <= (11'(X_MIN) + {1'b0, BallS})) ex_c = cur_step_c;
    else                                                    edge_c = 1'b0;
  end

  // Next-state and motion decision for the frame
  always_comb begin
    state_d = state_q;
    mx_d    = mx_q;
    my_d    = my_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    hold_d  = hold_q;
    bnc_d   = bnc_q;
    pop_c   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (space_c) begin
          state_d = ST_PAUSE;
          sx_d = mx_q;
          sy_d = my_q;
          mx_d = '0;
          my_d = '0;
        end else if (edge_c) begin
          mx_d    = ex_c;
          my_d    = ey_c;
          bnc_d   = BW'(BOUNCE_FRAMES - 1);
          hold_d  = hold_dec_c;
          state_d = ST_BOUNCE;
        end else if ((cnt_q != '0) && (hold_q == '0)) begin
          pop_c  = 1'b1;
          hold_d = HW'(HOLD_FRAMES - 1);
          case (pop_dir_c)
            DIR_W:   begin mx_d = '0;         my_d = pop_neg_c;  end
            DIR_S:   begin mx_d = '0;         my_d = pop_step_c; end
            DIR_A:   begin mx_d = pop_neg_c;  my_d = '0;         end
            default: begin mx_d = pop_step_c; my_d = '0;         end
          endcase
        end else begin
          hold_d = hold_dec_c;
        end
      end
      ST_BOUNCE: begin
        if (space_c) begin
          state_d = ST_PAUSE;
          sx_d = mx_q;
          sy_d = my_q;
          mx_d = '0;
          my_d = '0;
        end else begin
          mx_d   = ex_c;
          my_d   = ey_c;
          hold_d = hold_dec_c;
          if (bnc_q == '0) state_d = ST_RUN;
          else             bnc_d   = BW'(bnc_q - BW'(1));
        end
      end
      ST_PAUSE: begin
        if (space_c) begin
          state_d = ST_RUN;
          mx_d = sx_q;
          my_d = sy_q;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Queue bookkeeping: a pop frees a slot for a same-frame push
  always_comb begin
    push_ok_c = push_req_c && ((cnt_q != CW'(FIFO_DEPTH)) || pop_c);
    drop_c    = push_req_c && !push_ok_c;
    cnt_d     = cnt_q;
    if (push_ok_c && !pop_c)      cnt_d = CW'(cnt_q + CW'(1));
    else if (!push_ok_c && pop_c) cnt_d = CW'(cnt_q - CW'(1));
  end

  // Frame-rate state registers
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_RUN;
      prev_q  <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      mx_q    <= STEP_V;
      my_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      hold_q  <= '0;
      bnc_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= DIR_W;
    end else begin
      state_q <= state_d;
      prev_q  <= keycodes;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hold_q  <= hold_d;
      bnc_q   <= bnc_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_c;
      if (push_ok_c) begin
        fifo_q[wr_q] <= push_dir_c;
        wr_q         <= PW'(wr_q + PW'(1));
      end
      if (pop_c) rd_q <= PW'(rd_q + PW'(1));
    end
  end

  assign MotionX = mx_q;
  assign MotionY = my_q;
  assign Paused  = (state_q == ST_PAUSE);
  assign QCount  = 3'(cnt_q);
  assign Dropped = drop_q;

endmodule

// File: tb/tb_ball_motion_sched.sv
// Directed bench for ball_motion_sched: reset state, press latency and hold,
// round-robin order, queue overflow, bounce suppression, pause/resume.
module tb_ball_motion_sched;

  logic        frame_clk;
  logic        Reset;
  logic [31:0] keycodes;
  logic [9:0]  BallX, BallY, BallS;
  logic [9:0]  MotionX, MotionY;
  logic        Paused;
  logic [2:0]  QCount;
  logic        Dropped;

  int n_checks = 0;
  int n_errors = 0;

  ball_motion_sched dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycodes  (keycodes),
    .BallX     (BallX),
    .BallY     (BallY),
    .BallS     (BallS),
    .MotionX   (MotionX),
    .MotionY   (MotionY),
    .Paused    (Paused),
    .QCount    (QCount),
    .Dropped   (Dropped)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one frame; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    keycodes = '0;
    BallX    = 10'd320;
    BallY    = 10'd240;
    BallS    = 10'd4;
    run(2);
    check("rst_mx", 32'(MotionX), 32'h1);
    check("rst_my", 32'(MotionY), 32'h0);
    check("rst_qc", 32'(QCount), 32'h0);
    check("rst_paused", 32'(Paused), 32'h0);
    check("rst_drop", 32'(Dropped), 32'h0);
    Reset = 1'b0;
    tick();
    check("post_rst_mx", 32'(MotionX), 32'h1);
    check("post_rst_my", 32'(MotionY), 32'h0);
    check("post_rst_qc", 32'(QCount), 32'h0);

    // W at frame 0: queued only, popped at frame 1
    keycodes = 32'h0000_001A;
    tick();
    check("w_push_qc", 32'(QCount), 32'h1);
    check("w_nobypass_mx", 32'(MotionX), 32'h1);
    tick();
    check("w_pop_mx", 32'(MotionX), 32'h0);
    check("w_pop_my", 32'(MotionY), 32'h3FF);
    check("w_pop_qc", 32'(QCount), 32'h0);
    // S at frame 2 must wait for the hold to expire (pop at frame 9)
    keycodes = 32'h0000_161A;
    tick();
    check("s_push_qc", 32'(QCount), 32'h1);
    run(6);
    check("hold_f8_my", 32'(MotionY), 32'h3FF);
    check("hold_f8_qc", 32'(QCount), 32'h1);
    tick();
    check("s_pop_f9_my", 32'(MotionY), 32'h1);
    check("s_pop_f9_qc", 32'(QCount), 32'h0);

    // Round robin from ptr 0: S(1), A(2), D(3), W(0)
    keycodes = '0;
    pulse_reset();
    keycodes = 32'h0704_161A;
    tick();
    check("rr_f0_qc", 32'(QCount), 32'h1);
    tick();
    check("rr_s_mx", 32'(MotionX), 32'h0);
    check("rr_s_my", 32'(MotionY), 32'h1);
    check("rr_f1_qc", 32'(QCount), 32'h1);
    tick();
    check("rr_f2_qc", 32'(QCount), 32'h2);
    tick();
    check("rr_f3_qc", 32'(QCount), 32'h3);
    run(5);
    tick();
    check("rr_a_mx", 32'(MotionX), 32'h3FF);
    check("rr_a_my", 32'(MotionY), 32'h0);
    check("rr_f9_qc", 32'(QCount), 32'h2);
    run(7);
    tick();
    check("rr_d_mx", 32'(MotionX), 32'h1);
    check("rr_d_my", 32'(MotionY), 32'h0);
    run(7);
    tick();
    check("rr_w_mx", 32'(MotionX), 32'h0);
    check("rr_w_my", 32'(MotionY), 32'h3FF);
    check("rr_f25_qc", 32'(QCount), 32'h0);

    // Pause, then overflow the queue with five presses
    keycodes = '0;
    tick();
    keycodes = 32'h0000_002C;
    tick();
    check("pause_flag", 32'(Paused), 32'h1);
    check("pause_mx", 32'(MotionX), 32'h0);
    check("pause_my", 32'(MotionY), 32'h0);
    keycodes = 32'h0000_001A; tick();
    check("fill1_qc", 32'(QCount), 32'h1);
    keycodes = 32'h0000_0016; tick();
    check("fill2_qc", 32'(QCount), 32'h2);
    keycodes = 32'h0000_0004; tick();
    check("fill3_qc", 32'(QCount), 32'h3);
    keycodes = 32'h0000_0007; tick();
    check("fill4_qc", 32'(QCount), 32'h4);
    check("fill4_drop", 32'(Dropped), 32'h0);
    keycodes = 32'h0000_001A; tick();
    check("over_drop", 32'(Dropped), 32'h1);
    check("over_qc", 32'(QCount), 32'h4);
    keycodes = '0; tick();
    check("over_drop_end", 32'(Dropped), 32'h0);
    check("over_qc_hold", 32'(QCount), 32'h4);
    // Space again restores the pre-pause motion (0,-1)
    keycodes = 32'h0000_002C; tick();
    check("resume_flag", 32'(Paused), 32'h0);
    check("resume_mx", 32'(MotionX), 32'h0);
    check("resume_my", 32'(MotionY), 32'h3FF);
    check("resume_qc", 32'(QCount), 32'h4);

    // Bottom bounce with D queued: 4 frames suppressed, then D pops
    keycodes = '0;
    pulse_reset();
    BallY    = 10'd464;
    BallS    = 10'd16;
    keycodes = 32'h0000_0007;
    tick();
    check("bnc_my", 32'(MotionY), 32'h3FF);
    check("bnc_mx", 32'(MotionX), 32'h1);
    check("bnc_qc", 32'(QCount), 32'h1);
    BallY = 10'd240;
    run(3);
    tick();
    check("bnc_f4_qc", 32'(QCount), 32'h1);
    check("bnc_f4_my", 32'(MotionY), 32'h3FF);
    tick();
    check("bnc_pop_mx", 32'(MotionX), 32'h1);
    check("bnc_pop_my", 32'(MotionY), 32'h0);
    check("bnc_pop_qc", 32'(QCount), 32'h0);
    // Right edge flips X only, then top edge flips Y only
    BallX = 10'd630;
    tick();
    check("right_mx", 32'(MotionX), 32'h3FF);
    check("right_my", 32'(MotionY), 32'h0);
    BallX = 10'd320;
    BallY = 10'd10;
    tick();
    check("top_my", 32'(MotionY), 32'h1);
    check("top_mx", 32'(MotionX), 32'h3FF);
    BallY = 10'd240;

`ifdef BALL_ACCEL_EN
    // Repeated D pops accelerate 1,2,3,4 then saturate
    keycodes = '0;
    pulse_reset();
    for (int n = 0; n < 5; n++) begin
      keycodes = 32'h0000_0007;
      tick();
      keycodes = '0;
      tick();
      check("accel_mx", 32'(MotionX), 32'((n < 4) ? (n + 1) : 4));
      run(7);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
